// File: rtl/rr_mux_n_way_pkg.sv
// Shared types and helpers for the N-way round-robin word selector.
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mux_mode_e;

  // Index width for a given channel count, never narrower than one bit.
  function automatic int sel_width(input int ways);
    return (ways <= 2) ? 1 : $clog2(ways);
  endfunction

endpackage

// File: rtl/rr_mux_n_way_arbiter.sv
// Combinational round-robin picker: first requester strictly after ptr, wrapping.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int WAYS  = 8,
  parameter int SEL_W = sel_width(WAYS)
) (
  input  logic [WAYS-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  always_comb begin
    int idx;
    idx       = 0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    // Offsets 1..WAYS put the previous winner last in the scan.
    for (int k = 1; k <= WAYS; k++) begin
      idx = (int'(ptr) + k) % WAYS;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rr_mux_n_way.sv
// N-way W-bit selector with fixed or round-robin grant and a one-stage
// registered output.
//
// Handshake: a word moves on a rising edge where valid and ready are both 1.
// in_ready is combinational and one-hot-or-zero; out_valid/out_data/out_sel
// stay stable while out_valid=1 and out_ready=0.
module rr_mux_n_way
  import mux_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int WAYS  = 8,
  parameter int SEL_W = sel_width(WAYS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WAYS*WIDTH-1:0] in_data,
  input  logic [WAYS-1:0]       in_valid,
  output logic [WAYS-1:0]       in_ready,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      select,
  output logic [WIDTH-1:0]      out_data,
  output logic [SEL_W-1:0]      out_sel,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int PAD = 1 << SEL_W;

  mux_mode_e        mode_e;
  logic [SEL_W-1:0] rr_ptr;
  logic [SEL_W-1:0] rr_idx;
  logic             rr_valid;
  logic [SEL_W-1:0] grant;
  logic             grant_valid;
  logic             load_en;
  logic [PAD-1:0]   valid_pad;
  logic [WIDTH-1:0] grant_data;

  assign mode_e  = mux_mode_e'(mode);
  assign load_en = !out_valid || out_ready;

  // Padding lets an out-of-range select index safely; it never grants.
  always_comb begin
    valid_pad             = '0;
    valid_pad[WAYS-1:0]   = in_valid;
  end

  rr_arbiter #(
    .WAYS  (WAYS),
    .SEL_W (SEL_W)
  ) u_arb (
    .req       (in_valid),
    .ptr       (rr_ptr),
    .gnt_idx   (rr_idx),
    .gnt_valid (rr_valid)
  );

  always_comb begin
    grant       = rr_idx;
    grant_valid = rr_valid;
    if (mode_e == MODE_FIXED) begin
      grant       = select;
      grant_valid = (int'(select) < WAYS) && valid_pad[select];
    end
  end

  always_comb begin
    in_ready   = '0;
    grant_data = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (grant == SEL_W'(i)) begin
        in_ready[i] = rst_n && load_en && grant_valid;
        grant_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= SEL_W'(WAYS - 1);
    end else if (load_en) begin
      if (grant_valid) begin
        out_data  <= grant_data;
        out_sel   <= grant;
        out_valid <= 1'b1;
        if (mode_e == MODE_RR) rr_ptr <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_mux_n_way.sv
// Directed bench for rr_mux_n_way: stimulus pushes expected words, a negedge
// monitor pops them as the consumer accepts each output word.
module tb_rr_mux_n_way;

  logic         clk;
  logic         rst_n;
  logic [127:0] in_data;
  logic [7:0]   in_valid;
  logic [7:0]   in_ready;
  logic         mode;
  logic [2:0]   select;
  logic [15:0]  out_data;
  logic [2:0]   out_sel;
  logic         out_valid;
  logic         out_ready;

  // Six-way instance for out-of-range select handling.
  logic [5:0]   in_valid6;
  logic [5:0]   in_ready6;
  logic         mode6;
  logic [2:0]   select6;
  logic [15:0]  out_data6;
  logic [2:0]   out_sel6;
  logic         out_valid6;
  logic         out_ready6;

  logic [15:0] pat [8] = '{16'h5555, 16'hAAAA, 16'h00FF, 16'hFF00,
                           16'h3333, 16'hCCCC, 16'h0F0F, 16'hF0F0};

  logic [18:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  rr_mux_n_way #(.WIDTH(16), .WAYS(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .select    (select),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  rr_mux_n_way #(.WIDTH(16), .WAYS(6)) dut6 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data[95:0]),
    .in_valid  (in_valid6),
    .in_ready  (in_ready6),
    .mode      (mode6),
    .select    (select6),
    .out_data  (out_data6),
    .out_sel   (out_sel6),
    .out_valid (out_valid6),
    .out_ready (out_ready6)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, req);
    end
  endtask

  // One cycle: drive inputs, check in_ready, optionally expect a transfer of channel exp_s.
  task automatic step(input logic m, input logic [2:0] sel, input logic [7:0] vld,
                      input logic ordy, input logic [7:0] exp_rdy,
                      input bit push, input int exp_s);
    mode      = m;
    select    = sel;
    in_valid  = vld;
    out_ready = ordy;
    #1;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (push) exp_q.push_back({3'(exp_s), pat[exp_s]});
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: an output word is consumed at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word actual %0h_%0h required none", out_sel, out_data);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        if ({out_sel, out_data} !== e) begin
          errors++;
          $display("FAIL out_word actual %0h_%0h required %0h_%0h",
                   out_sel, out_data, e[18:16], e[15:0]);
        end
      end
    end
  end

  initial begin
    logic [2:0] rr_seq[9];
    logic [2:0] sp_seq[5];
    rr_seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    sp_seq = '{3'd2, 3'd4, 3'd7, 3'd2, 3'd4};

    for (int i = 0; i < 8; i++) in_data[i*16 +: 16] = pat[i];
    rst_n      = 1'b0;
    mode       = 1'b1;
    select     = 3'd0;
    in_valid   = 8'hFF;
    out_ready  = 1'b1;
    mode6      = 1'b0;
    select6    = 3'd6;
    in_valid6  = 6'h3F;
    out_ready6 = 1'b1;

    // Reset state, with requests pending
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_sel", 32'(out_sel), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;

    // 1. Fixed select sweep
    for (int k = 0; k < 8; k++)
      step(1'b0, 3'(k), 8'hFF, 1'b1, 8'(1 << k), 1'b1, k);

    // 2. RR, all requesting; pointer untouched by fixed mode so starts at 0
    for (int k = 0; k < 9; k++) begin
      step(1'b1, 3'd0, 8'hFF, 1'b1, 8'(1 << rr_seq[k]), 1'b1, int'(rr_seq[k]));
      check("rr_out_valid", 32'(out_valid), 32'd1);
    end

    // 3. RR sparse (pointer now 0)
    for (int k = 0; k < 5; k++)
      step(1'b1, 3'd0, 8'b1001_0100, 1'b1, 8'(1 << sp_seq[k]), 1'b1, int'(sp_seq[k]));

    // 4. Backpressure (pointer now 4)
    step(1'b1, 3'd0, 8'hFF, 1'b1, 8'h20, 1'b1, 5);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 3'd0, 8'hFF, 1'b0, 8'h00, 1'b0, 0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", 32'(out_data), 32'hCCCC);
      check("bp_out_sel", 32'(out_sel), 32'd5);
    end
    step(1'b1, 3'd0, 8'hFF, 1'b1, 8'h40, 1'b1, 6);
    step(1'b1, 3'd0, 8'hFF, 1'b1, 8'h80, 1'b1, 7);

    // 5. No grant: selected channel idle; six-way instance with select past range
    check("w6_idle_in_ready", 32'(in_ready6), 32'd0);
    check("w6_idle_out_valid", 32'(out_valid6), 32'd0);
    select6 = 3'd5;
    #1;
    check("w6_in_ready", 32'(in_ready6), 32'h20);
    step(1'b0, 3'd5, 8'hDF, 1'b1, 8'h00, 1'b0, 0);
    check("ng_out_valid", 32'(out_valid), 32'd0);
    check("ng_out_data_held", 32'(out_data), 32'hF0F0);
    check("ng_out_sel_held", 32'(out_sel), 32'd7);
    check("w6_out_valid", 32'(out_valid6), 32'd1);
    check("w6_out_sel", 32'(out_sel6), 32'd5);
    check("w6_out_data", 32'(out_data6), 32'hCCCC);
    select6 = 3'd6;
    step(1'b0, 3'd5, 8'hDF, 1'b1, 8'h00, 1'b0, 0);
    check("w6_oor_in_ready", 32'(in_ready6), 32'd0);
    check("w6_oor_out_valid", 32'(out_valid6), 32'd0);

    // 6. Reset mid-stream in RR mode (pointer still 7)
    step(1'b1, 3'd0, 8'hFF, 1'b1, 8'h01, 1'b1, 0);
    step(1'b1, 3'd0, 8'hFF, 1'b1, 8'h02, 1'b1, 1);
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    step(1'b1, 3'd0, 8'hFF, 1'b1, 8'h00, 1'b0, 0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data", 32'(out_data), 32'd0);
    check("mid_rst_out_sel", 32'(out_sel), 32'd0);
    exp_q.delete();
    rst_n = 1'b1;
    step(1'b1, 3'd0, 8'hFF, 1'b1, 8'h01, 1'b1, 0);
    step(1'b1, 3'd0, 8'h00, 1'b1, 8'h00, 1'b0, 0);
    check("drain_out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
